// File: rtl/iir_tb_pkg.sv
// Shared types for the IIR filter stimulus source: FSM states and coefficient select codes.
package iir_tb_pkg;

  localparam int DW_DEFAULT = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3,
    ST_TAIL  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Coefficient order on the filter: B0..B3 feed-forward, then A1, A2 feedback.
  localparam logic [2:0] SEL_H0 = 3'd0;
  localparam logic [2:0] SEL_H1 = 3'd1;
  localparam logic [2:0] SEL_H2 = 3'd2;
  localparam logic [2:0] SEL_H3 = 3'd3;
  localparam logic [2:0] SEL_H4 = 3'd4;
  localparam logic [2:0] SEL_H5 = 3'd5;

endpackage

// File: rtl/iir_stim_source_if.sv
// Load port, playback control and filter-facing sample/coefficient buses of the stimulus source.
interface iir_stim_source_if #(
  parameter int DW    = 14,
  parameter int AW    = 8,
  parameter int GAP_W = 4
);
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 coef_we;
  logic [2:0]           coef_sel;
  logic signed [DW-1:0] coef_data;
  logic                 start;
  logic [AW:0]          len;
  logic [GAP_W-1:0]     gap;
  logic signed [DW-1:0] dout;
  logic                 vout;
  logic signed [DW-1:0] h0, h1, h2, h3, h4, h5;
  logic                 busy;
  logic                 end_sim;

  modport master (
    input  wr_en, wr_addr, wr_data, coef_we, coef_sel, coef_data, start, len, gap,
    output dout, vout, h0, h1, h2, h3, h4, h5, busy, end_sim
  );

  modport slave (
    output wr_en, wr_addr, wr_data, coef_we, coef_sel, coef_data, start, len, gap,
    input  dout, vout, h0, h1, h2, h3, h4, h5, busy, end_sim
  );
endinterface

// File: rtl/iir_stim_ram.sv
// Sample buffer: one write port, one registered read port, contents never reset.
module iir_stim_ram #(
  parameter int DW = 14,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_data
);
  localparam int DEPTH = 1 << AW;

  logic signed [DW-1:0] mem [DEPTH];

  // Read data holds between reads so the playback FSM controls exactly when it moves.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/iir_stim_source.sv
// Plays preloaded samples into the IIR filter with a programmable gap, drives its
// coefficient registers, and raises end_sim once the filter has had TAIL cycles to drain.
module iir_stim_source
  import iir_tb_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = 8,
  parameter int GAP_W = 4,
  parameter int TAIL  = 16
) (
  input logic               clk,
  input logic               rst,
  iir_stim_source_if.master bus
);
  localparam int             PW      = AW + 1;
  localparam int             DEPTH   = 1 << AW;
  localparam logic [PW-1:0]  LEN_MAX = PW'(DEPTH);
  localparam int             TAIL_W  = (TAIL < 2) ? 1 : $clog2(TAIL);

  state_t               state;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        len_q;
  logic [GAP_W-1:0]     gap_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [TAIL_W-1:0]    tail_cnt;
  logic                 vout_q;
  logic                 busy_q;
  logic                 end_sim_q;
  logic signed [DW-1:0] dout_hold;
  logic signed [DW-1:0] h_q [6];
  logic signed [DW-1:0] rd_data;
  logic                 rd_en;
  logic                 last;
  logic                 start_ok;

  // rd_ptr counts reads issued, so in SEND it already points past the sample on the bus.
  always_comb begin
    last     = (rd_ptr == len_q);
    start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start && (bus.len != '0);
    rd_en    = 1'b0;
    case (state)
      ST_FETCH: rd_en = 1'b1;
      ST_SEND:  rd_en = !last && (gap_q == '0);
      ST_GAP:   rd_en = (gap_cnt == '0);
      default:  rd_en = 1'b0;
    endcase
  end

  iir_stim_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en && !busy_q),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      tail_cnt  <= '0;
      vout_q    <= 1'b0;
      busy_q    <= 1'b0;
      end_sim_q <= 1'b0;
      dout_hold <= '0;
      for (int i = 0; i < 6; i++) h_q[i] <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (vout_q) dout_hold <= rd_data;
      if (bus.coef_we && !busy_q && (bus.coef_sel <= SEL_H5)) begin
        for (int i = 0; i < 6; i++)
          if (bus.coef_sel == 3'(i)) h_q[i] <= bus.coef_data;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state     <= ST_FETCH;
            len_q     <= (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
            gap_q     <= bus.gap;
            rd_ptr    <= '0;
            busy_q    <= 1'b1;
            end_sim_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          state  <= ST_SEND;
          vout_q <= 1'b1;
        end
        ST_SEND: begin
          if (last) begin
            vout_q <= 1'b0;
            if (TAIL == 0) begin
              state     <= ST_DONE;
              busy_q    <= 1'b0;
              end_sim_q <= 1'b1;
            end else begin
              state    <= ST_TAIL;
              tail_cnt <= TAIL_W'(TAIL - 1);
            end
          end else if (gap_q == '0) begin
            vout_q <= 1'b1;
          end else begin
            state   <= ST_GAP;
            vout_q  <= 1'b0;
            gap_cnt <= gap_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state  <= ST_SEND;
            vout_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_TAIL: begin
          if (tail_cnt == '0) begin
            state     <= ST_DONE;
            busy_q    <= 1'b0;
            end_sim_q <= 1'b1;
          end else begin
            tail_cnt <= tail_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data arrives in the SEND cycle itself; elsewhere the last sent sample is held.
  assign bus.dout    = vout_q ? rd_data : dout_hold;
  assign bus.vout    = vout_q;
  assign bus.busy    = busy_q;
  assign bus.end_sim = end_sim_q;
  assign bus.h0      = h_q[0];
  assign bus.h1      = h_q[1];
  assign bus.h2      = h_q[2];
  assign bus.h3      = h_q[3];
  assign bus.h4      = h_q[4];
  assign bus.h5      = h_q[5];
endmodule
